csa_ecm_reader: RTL and testbench

- Consumes the 36-bit ECM insertion descriptors issued by the ECM scheduler (csa_ecm_ctrl) and fetches the addressed 188-byte ECM packet from packet memory.
- Buffers the packet locally, checks the sync byte, and rewrites the continuity counter with the counter carried in the descriptor.
- Streams the packet to the TS output mux under a request/grant handshake.

---
 rtl/csa_ecm_reader_if.sv | 41 ++++
 rtl/csa_ecm_reader.sv | 171 +++++++++++++++++
 tb/tb_csa_ecm_reader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_ecm_reader_if.sv
// Bus bundle for the ECM reader: descriptor intake, packet-memory read port,
// and the TS output port toward the mux.
//
// Handshakes:
//   - ecm_addr_din_en is a one-cycle strobe. There is no back-pressure: a
//     descriptor offered while the FIFO is full is dropped and counted.
//   - mem_rd asks for one byte at mem_addr. mem_din carries that byte exactly
//     RD_LAT cycles later. The read port never stalls.
//   - ts_req stays high until ts_grant is sampled high. The packet then leaves
//     on consecutive cycles with ts_dout_en=1 and no gaps.
//     ts_sop marks byte 0 and ts_eop marks the last byte.
interface csa_ecm_reader_if;
    logic [35:0] ecm_addr_din;
    logic        ecm_addr_din_en;
    logic        mem_rd;
    logic [26:0] mem_addr;
    logic [7:0]  mem_din;
    logic        ts_req;
    logic        ts_grant;
    logic [7:0]  ts_dout;
    logic        ts_dout_en;
    logic        ts_sop;
    logic        ts_eop;
    logic        desc_err;
    logic        sync_err;
    logic [15:0] ovf_cnt;

    // Environment side: scheduler, packet memory and output mux.
    modport master (
        output ecm_addr_din, ecm_addr_din_en, mem_din, ts_grant,
        input  mem_rd, mem_addr, ts_req, ts_dout, ts_dout_en, ts_sop, ts_eop,
        input  desc_err, sync_err, ovf_cnt
    );

    // Reader side.
    modport slave (
        input  ecm_addr_din, ecm_addr_din_en, mem_din, ts_grant,
        output mem_rd, mem_addr, ts_req, ts_dout, ts_dout_en, ts_sop, ts_eop,
        output desc_err, sync_err, ovf_cnt
    );
endinterface

// File: rtl/csa_ecm_reader.sv
// ECM packet reader. Queues insertion descriptors and fetches each packet
// from memory into a local buffer. It checks the sync byte, patches the
// continuity counter, and then streams the packet to the TS mux.
module csa_ecm_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2,
    parameter int PKT_LEN    = 188
) (
    input  logic             clk,
    input  logic             rst_n,
    csa_ecm_reader_if.slave  bus,
    output logic [2:0]       dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(PKT_LEN + 1);
    localparam logic [7:0]       SYNC_BYTE = 8'h47;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_LEN - 1);
    localparam logic [IDX_W-1:0] LEN_IDX   = IDX_W'(PKT_LEN);

    typedef enum logic [2:0] {IDLE, FETCH, CHECK, REQ, SEND} state_t;

    state_t state_q, state_d;

    // Each descriptor FIFO entry is {cc[3:0], base[26:0]}.
    // The marker and type fields are only needed at intake.
    logic [30:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, desc_ok, push, pop;

    logic [3:0]       cc_q;
    logic [26:0]      base_q;
    logic [IDX_W-1:0] idx_q;      // read index in FETCH, transmit index in SEND
    logic [IDX_W-1:0] wr_idx_q;   // buffer capture index
    logic [RD_LAT-1:0] rd_pipe;   // tracks outstanding reads so data lands on time
    logic             cap_vld;
    logic [7:0]       pkt_buf [PKT_LEN];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign desc_ok    = bus.ecm_addr_din[31] && (bus.ecm_addr_din[30:27] == 4'b0010);
    assign push       = bus.ecm_addr_din_en && desc_ok && !fifo_full;
    assign cap_vld    = rd_pipe[RD_LAT-1];
    assign dbg_state  = state_q;

    // Descriptor storage; only the pointers need a reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.ecm_addr_din[35:32], bus.ecm_addr_din[26:0]};
    end

    // FIFO pointers: a push and a pop may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Intake error reporting: malformed pulse and saturating overflow count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.desc_err <= 1'b0;
            bus.ovf_cnt  <= '0;
        end else begin
            bus.desc_err <= bus.ecm_addr_din_en && !desc_ok;
            if (bus.ecm_addr_din_en && desc_ok && fifo_full && (bus.ovf_cnt != 16'hFFFF))
                bus.ovf_cnt <= bus.ovf_cnt + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and all FSM-driven outputs.
    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_addr   = '0;
        bus.ts_req     = 1'b0;
        bus.ts_dout_en = 1'b0;
        bus.ts_dout    = '0;
        bus.ts_sop     = 1'b0;
        bus.ts_eop     = 1'b0;
        bus.sync_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (idx_q != LEN_IDX) begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = base_q + 27'(idx_q);
                end
                if (cap_vld && (wr_idx_q == LAST_IDX)) state_d = CHECK;
            end
            CHECK: begin
                if (pkt_buf[0] == SYNC_BYTE) begin
                    state_d = REQ;
                end else begin
                    bus.sync_err = 1'b1;
                    state_d      = IDLE;
                end
            end
            REQ: begin
                bus.ts_req = 1'b1;
                if (bus.ts_grant) state_d = SEND;
            end
            SEND: begin
                bus.ts_dout_en = 1'b1;
                bus.ts_dout    = pkt_buf[idx_q];
                bus.ts_sop     = (idx_q == '0);
                if (idx_q == LAST_IDX) begin
                    bus.ts_eop = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-packet bookkeeping: descriptor latch, indices and read-latency pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q     <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            wr_idx_q <= '0;
            rd_pipe  <= '0;
        end else begin
            rd_pipe[0] <= bus.mem_rd;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cc_q     <= fifo_mem[rd_ptr[PTR_W-1:0]][30:27];
                        base_q   <= fifo_mem[rd_ptr[PTR_W-1:0]][26:0];
                        idx_q    <= '0;
                        wr_idx_q <= '0;
                    end
                end
                FETCH: begin
                    if (bus.mem_rd) idx_q    <= idx_q + IDX_W'(1);
                    if (cap_vld)    wr_idx_q <= wr_idx_q + IDX_W'(1);
                end
                CHECK:   idx_q <= '0;
                SEND:    idx_q <= idx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Packet buffer: capture returning bytes, then patch the CC nibble of byte 3.
    always_ff @(posedge clk) begin
        if (cap_vld)
            pkt_buf[wr_idx_q] <= bus.mem_din;
        else if ((state_q == CHECK) && (pkt_buf[0] == SYNC_BYTE))
            pkt_buf[3] <= {pkt_buf[3][7:4], cc_q};
    end

endmodule

// File: tb/tb_csa_ecm_reader.sv
// Directed bench for csa_ecm_reader.
module tb_csa_ecm_reader;
    localparam int RD_LAT  = 2;
    localparam int PKT_LEN = 188;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    csa_ecm_reader_if bus();

    csa_ecm_reader #(.FIFO_DEPTH(4), .RD_LAT(RD_LAT), .PKT_LEN(PKT_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory image. Byte 0 is the sync byte, except in page 0x400, which holds
    // a corrupt packet. Bytes 1..3 are 01 02 1A. Each later byte is its offset
    // plus the page's low byte.
    function automatic logic [7:0] mem_val(input logic [26:0] a);
        logic [18:0] page;
        page = a[26:8];
        case (a[7:0])
            8'd0:    return (page == 19'h00400) ? 8'h00 : 8'h47;
            8'd1:    return 8'h01;
            8'd2:    return 8'h02;
            8'd3:    return 8'h1A;
            default: return a[7:0] + page[7:0];
        endcase
    endfunction

    function automatic logic [35:0] mk_desc(input logic [3:0] cc, input logic [26:0] base);
        return {cc, 1'b1, 4'b0010, base};
    endfunction

    // ---------------- memory model ----------------
    logic [7:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= bus.mem_rd ? mem_val(bus.mem_addr) : 8'h00;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_din = rd_pipe[RD_LAT-1];

    // ---------------- grant driver ----------------
    logic auto_grant = 1'b0;
    logic manual_grant = 1'b0;
    initial begin
        bus.ts_grant = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.ts_grant = auto_grant ? bus.ts_req : manual_grant;
        end
    end

    // ---------------- monitor + scoreboard ----------------
    logic [30:0] exp_q[$];          // {cc, base} of each packet expected out
    logic [30:0] cur_exp = '0;
    logic [7:0]  exp_b;
    logic [7:0]  last_pkt [PKT_LEN];
    logic [26:0] first_addr = '0, last_addr = '0, prev_addr = '0;
    int rd_cnt = 0, rd_run = 0, addr_err = 0, desc_err_cnt = 0, sync_err_cnt = 0;
    int req_cnt = 0, en_cnt = 0, pkt_cnt = 0, framing_err = 0, data_err = 0, cur_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_len = 0;
            rd_run  = 0;
        end else begin
            if (bus.mem_rd) begin
                if (rd_run == 0) first_addr = bus.mem_addr;
                else if (bus.mem_addr !== prev_addr + 27'd1) addr_err++;
                prev_addr = bus.mem_addr;
                last_addr = bus.mem_addr;
                rd_cnt++;
                rd_run++;
            end else begin
                rd_run = 0;
            end
            if (bus.desc_err) desc_err_cnt++;
            if (bus.sync_err) sync_err_cnt++;
            if (bus.ts_req)   req_cnt++;
            if (bus.ts_dout_en) begin
                en_cnt++;
                if (bus.ts_sop) begin
                    if (cur_len != 0) framing_err++;
                    cur_len = 0;
                    if (exp_q.size() == 0) begin
                        data_err++;
                        cur_exp = '0;
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                end else if (cur_len == 0) begin
                    framing_err++;
                end
                exp_b = mem_val(cur_exp[26:0] + 27'(cur_len));
                if (cur_len == 3) exp_b = {exp_b[7:4], cur_exp[30:27]};
                if (bus.ts_dout !== exp_b) data_err++;
                if (cur_len < PKT_LEN) last_pkt[cur_len] = bus.ts_dout;
                cur_len++;
                if (bus.ts_eop) begin
                    if (cur_len != PKT_LEN) framing_err++;
                    pkt_cnt++;
                    cur_len = 0;
                end else if (cur_len >= PKT_LEN) begin
                    framing_err++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_desc(input logic [35:0] d);
        bus.ecm_addr_din    = d;
        bus.ecm_addr_din_en = 1'b1;
        tick(1);
        bus.ecm_addr_din_en = 1'b0;
    endtask

    task automatic wait_pkts(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && pkt_cnt < target; i++) tick(1);
        check(tag, pkt_cnt, target);
    endtask

    // ---------------- directed sequence ----------------
    int s_rd, s_de, s_req, s_se, s_en, s_pkt;

    initial begin
        bus.ecm_addr_din    = '0;
        bus.ecm_addr_din_en = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check("rst_state", dbg_state, 0);
        check("rst_ctrl", {bus.mem_rd, bus.ts_req, bus.ts_dout_en, bus.ts_sop,
                           bus.ts_eop, bus.desc_err, bus.sync_err}, 0);
        check("rst_ovf", bus.ovf_cnt, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_dout", bus.ts_dout, 0);
        rst_n = 1'b1;
        tick(1);

        // 1: basic packet, first-read latency, CC rewrite
        s_rd = rd_cnt;
        exp_q.push_back({4'h5, 27'h0012300});
        drive_desc(mk_desc(4'h5, 27'h0012300));
        check("lat_c1_mem_rd", bus.mem_rd, 0);
        tick(1);
        check("lat_c2_mem_rd", bus.mem_rd, 1);
        check("lat_c2_addr", bus.mem_addr, 27'h0012300);
        auto_grant = 1'b1;
        wait_pkts(1, 600, "t1_pkt_done");
        check("t1_rd_cnt", rd_cnt - s_rd, 188);
        check("t1_first_addr", first_addr, 27'h0012300);
        check("t1_last_addr", last_addr, 27'h00123BB);
        check("t1_addr_seq", addr_err, 0);
        check("t1_byte0", last_pkt[0], 8'h47);
        check("t1_byte3", last_pkt[3], 8'h15);
        check("t1_byte187", last_pkt[187], 8'hDE);
        check("t1_framing", framing_err, 0);
        check("t1_data", data_err, 0);

        // 2: malformed descriptors (bad type, then missing marker)
        s_de = desc_err_cnt; s_rd = rd_cnt; s_req = req_cnt;
        drive_desc({4'h5, 1'b1, 4'b0011, 27'h0012300});
        check("t2_desc_err_pulse", bus.desc_err, 1);
        tick(1);
        check("t2_desc_err_clear", bus.desc_err, 0);
        drive_desc({4'h5, 1'b0, 4'b0010, 27'h0012300});
        tick(20);
        check("t2_desc_err_cnt", desc_err_cnt - s_de, 2);
        check("t2_no_rd", rd_cnt - s_rd, 0);
        check("t2_no_req", req_cnt - s_req, 0);

        // 3: bad sync byte is fetched then discarded
        s_rd = rd_cnt; s_se = sync_err_cnt; s_req = req_cnt; s_en = en_cnt;
        drive_desc(mk_desc(4'h3, 27'h0040000));
        tick(250);
        check("t3_rd_cnt", rd_cnt - s_rd, 188);
        check("t3_sync_err", sync_err_cnt - s_se, 1);
        check("t3_no_req", req_cnt - s_req, 0);
        check("t3_no_out", en_cnt - s_en, 0);
        check("t3_idle", dbg_state, 0);

        // 4: six back-to-back descriptors, one lost to a full FIFO
        s_pkt = pkt_cnt;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) exp_q.push_back({4'(k + 1), 27'(32'h20000 + k * 256)});
            bus.ecm_addr_din    = mk_desc(4'(k + 1), 27'(32'h20000 + k * 256));
            bus.ecm_addr_din_en = 1'b1;
            tick(1);
        end
        bus.ecm_addr_din_en = 1'b0;
        check("t4_ovf", bus.ovf_cnt, 1);
        wait_pkts(s_pkt + 5, 3000, "t4_pkts");
        tick(400);
        check("t4_no_extra", pkt_cnt, s_pkt + 5);
        check("t4_last_cc", last_pkt[3], 8'h15);
        check("t4_data", data_err, 0);
        check("t4_framing", framing_err, 0);
        check("t4_queue_drained", exp_q.size(), 0);

        // 5: grant withheld for 1000 cycles
        auto_grant = 1'b0;
        manual_grant = 1'b0;
        exp_q.push_back({4'hC, 27'h0030000});
        drive_desc(mk_desc(4'hC, 27'h0030000));
        for (int i = 0; i < 400 && !bus.ts_req; i++) tick(1);
        check("t5_req_up", bus.ts_req, 1);
        s_req = req_cnt; s_en = en_cnt;
        tick(1000);
        check("t5_req_held", req_cnt - s_req, 1000);
        check("t5_no_out", en_cnt - s_en, 0);
        manual_grant = 1'b1;
        check("t5_no_byte_yet", bus.ts_dout_en, 0);
        tick(1);
        manual_grant = 1'b0;
        check("t5_first_en", bus.ts_dout_en, 1);
        check("t5_first_sop", bus.ts_sop, 1);
        check("t5_first_byte", bus.ts_dout, 8'h47);
        check("t5_req_drop", bus.ts_req, 0);
        wait_pkts(pkt_cnt + 1, 400, "t5_pkt_done");
        check("t5_cc", last_pkt[3], 8'h1C);
        check("t5_data", data_err, 0);

        // 6: reset at byte 100 of SEND, then a fresh packet
        auto_grant = 1'b1;
        exp_q.push_back({4'h7, 27'h0050000});
        drive_desc(mk_desc(4'h7, 27'h0050000));
        for (int i = 0; i < 400 && !bus.ts_dout_en; i++) tick(1);
        check("t6_send_start", bus.ts_sop, 1);
        tick(100);
        check("t6_byte100", bus.ts_dout, 8'h64);
        s_pkt = pkt_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {bus.mem_rd, bus.ts_req, bus.ts_dout_en, bus.ts_sop,
                              bus.ts_eop, bus.desc_err, bus.sync_err}, 0);
        check("t6_rst_dout", bus.ts_dout, 0);
        check("t6_rst_state", dbg_state, 0);
        check("t6_rst_ovf", bus.ovf_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("t6_no_eop", pkt_cnt, s_pkt);
        s_rd = rd_cnt;
        exp_q.push_back({4'h9, 27'h0060000});
        drive_desc(mk_desc(4'h9, 27'h0060000));
        wait_pkts(s_pkt + 1, 600, "t6_pkt_done");
        check("t6_first_addr", first_addr, 27'h0060000);
        check("t6_rd_cnt", rd_cnt - s_rd, 188);
        check("t6_cc", last_pkt[3], 8'h19);
        check("t6_data", data_err, 0);
        check("t6_framing", framing_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Time bound for the whole run.
    initial begin
        #1000000;
        check("watchdog", 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
